// File: rtl/req_traffic_gen.sv
// Request-channel traffic generator: a programmed number of beats separated by idle gaps,
// with VALID_READY or READY_VALID ordering. Define REQ_GEN_LFSR_EN for LFSR payload data.
module req_traffic_gen #(
  parameter int          DATA_SIZE = 16,
  parameter              CNFG      = "VALID_READY",
  parameter int          MAX_REQ   = 255,
  parameter int          MAX_GAP   = 15,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         B_REQ     = $clog2(MAX_REQ + 1),
  localparam int         B_GAP     = $clog2(MAX_GAP + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [B_REQ-1:0]     num_req_i,
  input  logic [B_GAP-1:0]     gap_i,
  output logic                 req_valid_o,
  output logic [DATA_SIZE-1:0] req_data_o,
  input  logic                 req_ready_i,
  output logic                 done_o,
  output logic [B_REQ-1:0]     sent_count_o
);

  localparam bit IS_RV = (CNFG == "READY_VALID");
  localparam bit IS_VR = (CNFG == "VALID_READY");

`ifdef REQ_GEN_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  if (!IS_RV && !IS_VR) begin : g_bad_cnfg
    $error("req_traffic_gen: CNFG must be \"VALID_READY\" or \"READY_VALID\"");
  end

  if (LFSR_ON && ((SEED == 16'h0000) || (DATA_SIZE != 16))) begin : g_bad_lfsr
    $error("req_traffic_gen: LFSR payload needs a non-zero SEED and DATA_SIZE of 16");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [B_REQ-1:0]       num_q, num_d;
  logic [B_GAP-1:0]       gap_q, gap_d;
  logic [B_GAP-1:0]       gapCnt_q, gapCnt_d;
  logic [B_REQ-1:0]       count_q, count_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;

  logic [DATA_SIZE-1:0]   dataStart;
  logic [DATA_SIZE-1:0]   dataNext;
  logic [B_REQ-1:0]       countInc;
  logic                   xfer;

`ifdef REQ_GEN_LFSR_EN
  // Galois right-shift LFSR, x^16+x^14+x^13+x^11+1; steps only on a transfer.
  assign dataStart = DATA_SIZE'(SEED);
  assign dataNext  = data_q[0] ? ((data_q >> 1) ^ DATA_SIZE'(16'hB400)) : (data_q >> 1);
`else
  assign dataStart = '0;
  assign dataNext  = data_q + DATA_SIZE'(1);
`endif

  // READY_VALID offers only while ready is high, so valid is never raised against a low ready.
  assign req_valid_o  = IS_RV ? ((state_q == OFFER) && req_ready_i) : valid_q;
  assign req_data_o   = (state_q == IDLE) ? '0 : data_q;
  assign done_o       = (state_q == DONE);
  assign sent_count_o = count_q;

  assign xfer     = req_valid_o && req_ready_i;
  assign countInc = count_q + B_REQ'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      num_q    <= '0;
      gap_q    <= '0;
      gapCnt_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      gap_q    <= gap_d;
      gapCnt_q <= gapCnt_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    gap_d    = gap_q;
    gapCnt_d = gapCnt_q;
    count_d  = count_q;
    data_d   = data_q;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          count_d = '0;
          if (num_req_i != '0) begin
            num_d   = num_req_i;
            gap_d   = gap_i;
            data_d  = dataStart;
            state_d = OFFER;
          end else begin
            state_d = DONE;
          end
        end
      end

      // A VALID_READY offer cannot be withdrawn, so an abort waits for the pending beat.
      OFFER: begin
        if (xfer) begin
          count_d = countInc;
          data_d  = dataNext;
          if (!en_i) begin
            state_d = IDLE;
          end else if (countInc == num_q) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            state_d  = GAP;
            gapCnt_d = gap_q;
          end
        end else if (!en_i && IS_RV) begin
          state_d = IDLE;
        end
      end

      GAP: begin
        gapCnt_d = gapCnt_q - B_GAP'(1);
        if (!en_i) begin
          state_d = IDLE;
        end else if (gapCnt_q == B_GAP'(1)) begin
          state_d = OFFER;
        end
      end

      DONE: begin
        if (!en_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    valid_d = (state_d == OFFER) && !IS_RV;
  end

endmodule

// File: tb/tb_req_traffic_gen.sv
// Self-checking bench for req_traffic_gen: one VALID_READY and one READY_VALID instance
// driven with random ready/run settings and compared against a beat-level reference model.
module tb_req_traffic_gen;

  localparam int DW   = 16;
  localparam int MAXR = 255;
  localparam int MAXG = 15;
  localparam int BR   = $clog2(MAXR + 1);
  localparam int BG   = $clog2(MAXG + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enVr, enRv;
  logic [BR-1:0] numIn;
  logic [BG-1:0] gapIn;
  logic          readyIn;

  logic          vrValid, rvValid;
  logic [DW-1:0] vrData, rvData;
  logic          vrDone, rvDone;
  logic [BR-1:0] vrCount, rvCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_traffic_gen #(.DATA_SIZE(DW), .CNFG("VALID_READY"), .MAX_REQ(MAXR), .MAX_GAP(MAXG)) dutVr (
    .clk_i(clk), .rst_i(rst), .en_i(enVr), .num_req_i(numIn), .gap_i(gapIn),
    .req_valid_o(vrValid), .req_data_o(vrData), .req_ready_i(readyIn),
    .done_o(vrDone), .sent_count_o(vrCount)
  );

  req_traffic_gen #(.DATA_SIZE(DW), .CNFG("READY_VALID"), .MAX_REQ(MAXR), .MAX_GAP(MAXG)) dutRv (
    .clk_i(clk), .rst_i(rst), .en_i(enRv), .num_req_i(numIn), .gap_i(gapIn),
    .req_valid_o(rvValid), .req_data_o(rvData), .req_ready_i(readyIn),
    .done_o(rvDone), .sent_count_o(rvCount)
  );

  // Payload of the k-th beat of a run, straight from the sequence definition.
  function automatic logic [DW-1:0] expData(input int k);
    logic [DW-1:0] d;
`ifdef REQ_GEN_LFSR_EN
    d = 16'hACE1;
    for (int i = 0; i < k; i++) d = d[0] ? ((d >> 1) ^ 16'hB400) : (d >> 1);
`else
    d = DW'(k);
`endif
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setEn(input bit rv, input logic v);
    if (rv) enRv = v;
    else    enVr = v;
  endtask

  task automatic sampleDut(input bit rv, output logic v, output logic [DW-1:0] d,
                           output logic dn, output logic [BR-1:0] c);
    if (rv) begin
      v = rvValid; d = rvData; dn = rvDone; c = rvCount;
    end else begin
      v = vrValid; d = vrData; dn = vrDone; c = vrCount;
    end
  endtask

  // One full run: the model knows the cycle from which the generator is offering
  // (one cycle after start, or gap+1 cycles after each transfer) and the beat index.
  task automatic applyStimulus(input bit rv, input int num, input int gap, input int readyPct);
    int            cyc, nextOffer, sent;
    bit            finished, expV;
    logic          v, dn;
    logic [DW-1:0] d;
    logic [BR-1:0] c;

    @(negedge clk);
    numIn   = BR'(num);
    gapIn   = BG'(gap);
    readyIn = 1'b0;
    setEn(rv, 1'b1);
    nextOffer = 1;
    sent      = 0;
    finished  = 0;
    cyc       = 0;
    while (!finished && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      readyIn = ($urandom_range(99) < readyPct);
      numIn   = BR'($urandom);
      gapIn   = BG'($urandom);
      #1;
      sampleDut(rv, v, d, dn, c);
      if (sent == num) begin
        checkOutput("doneHigh", 32'(dn), 32'd1);
        checkOutput("validAfterDone", 32'(v), 32'd0);
        checkOutput("finalCount", 32'(c), 32'(num));
        finished = 1;
      end else begin
        expV = (cyc < nextOffer) ? 1'b0 : (rv ? readyIn : 1'b1);
        checkOutput("valid", 32'(v), 32'(expV));
        checkOutput("doneLow", 32'(dn), 32'd0);
        checkOutput("count", 32'(c), 32'(sent));
        if (expV) checkOutput("data", 32'(d), 32'(expData(sent)));
        if (expV && readyIn) begin
          sent++;
          nextOffer = cyc + gap + 1;
        end
      end
    end
    if (!finished) checkOutput("runTimeout", 32'd0, 32'd1);
    setEn(rv, 1'b0);
    @(negedge clk);
    #1;
    sampleDut(rv, v, d, dn, c);
    checkOutput("doneCleared", 32'(dn), 32'd0);
    checkOutput("countHeld", 32'(c), 32'(num));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          v, dn;
    logic [DW-1:0] d;
    logic [BR-1:0] c;

    rst = 1'b1; enVr = 1'b0; enRv = 1'b0; numIn = '0; gapIn = '0; readyIn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      sampleDut(1'(m), v, d, dn, c);
      checkOutput("rstValid", 32'(v), 32'd0);
      checkOutput("rstData", 32'(d), 32'd0);
      checkOutput("rstDone", 32'(dn), 32'd0);
      checkOutput("rstCount", 32'(c), 32'd0);
    end
    rst = 1'b0;

    $display("[TB] directed runs");
    applyStimulus(1'b0, 4, 0, 100);
    applyStimulus(1'b0, 3, 2, 50);
    applyStimulus(1'b1, 5, 1, 50);
    applyStimulus(1'b1, 4, 0, 100);
    applyStimulus(1'b0, 20, MAXG, 80);
    applyStimulus(1'b0, MAXR, 0, 100);

    $display("[TB] random runs");
    for (int r = 0; r < 8; r++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 12),
                    $urandom_range(0, 4), $urandom_range(30, 100));

    $display("[TB] zero-length run");
    @(negedge clk);
    numIn = '0; gapIn = '0; enVr = 1'b1;
    @(negedge clk); #1;
    checkOutput("zeroDone", 32'(vrDone), 32'd1);
    checkOutput("zeroCount", 32'(vrCount), 32'd0);
    checkOutput("zeroValid", 32'(vrValid), 32'd0);
    enVr = 1'b0;
    @(negedge clk); #1;
    checkOutput("zeroDoneClear", 32'(vrDone), 32'd0);

    $display("[TB] abort VALID_READY with beat pending");
    numIn = BR'(10); gapIn = '0; readyIn = 1'b0; enVr = 1'b1;
    @(negedge clk); #1;
    checkOutput("abortValid", 32'(vrValid), 32'd1);
    enVr = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("abortHold", 32'(vrValid), 32'd1);
      checkOutput("abortData", 32'(vrData), 32'(expData(0)));
    end
    @(negedge clk);
    readyIn = 1'b1;
    #1;
    checkOutput("abortXferValid", 32'(vrValid), 32'd1);
    @(negedge clk);
    readyIn = 1'b0;
    #1;
    checkOutput("abortIdleValid", 32'(vrValid), 32'd0);
    checkOutput("abortDone", 32'(vrDone), 32'd0);
    checkOutput("abortCount", 32'(vrCount), 32'd1);

    $display("[TB] abort READY_VALID during gap");
    @(negedge clk);
    numIn = BR'(5); gapIn = BG'(3); readyIn = 1'b1; enRv = 1'b1;
    @(negedge clk); #1;
    checkOutput("rvAbortFirst", 32'(rvValid), 32'd1);
    @(negedge clk); #1;
    checkOutput("rvAbortGap", 32'(rvValid), 32'd0);
    enRv = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      checkOutput("rvAbortIdle", 32'(rvValid), 32'd0);
    end
    checkOutput("rvAbortCount", 32'(rvCount), 32'd1);
    checkOutput("rvAbortDone", 32'(rvDone), 32'd0);

    $display("[TB] reset mid-offer");
    @(negedge clk);
    numIn = BR'(5); gapIn = '0; readyIn = 1'b1; enVr = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    readyIn = 1'b0;
    #1;
    checkOutput("preRstValid", 32'(vrValid), 32'd1);
    checkOutput("preRstCount", 32'(vrCount), 32'd2);
    checkOutput("preRstData", 32'(vrData), 32'(expData(2)));
    #1 rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", 32'(vrValid), 32'd0);
    checkOutput("asyncRstCount", 32'(vrCount), 32'd0);
    checkOutput("asyncRstData", 32'(vrData), 32'd0);
    @(negedge clk);
    rst = 1'b0; enVr = 1'b0;
    @(negedge clk); #1;
    checkOutput("postRstIdle", 32'(vrValid), 32'd0);
    applyStimulus(1'b0, 3, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
